// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter for the picorv32 native
// memory bus. Master 0 is the CPU core, master 1 the loader/debug port.
// The owner's request passes combinationally to the slave side; a grant
// holds until the transfer completes or the owner withdraws its request.
// Optional build macro ARB_TIMEOUT_EN adds a stall watchdog that force-
// completes a granted transfer after TIMEOUT_CYCLES cycles without s_ready.
module mem_bus_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_valid,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [DW/8-1:0] m0_wstrb,
   output logic            m0_ready,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_valid,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_wstrb,
   output logic            m1_ready,
   output logic [DW-1:0]   m1_rdata,
   output logic            s_valid,
   output logic [AW-1:0]   s_addr,
   output logic [DW-1:0]   s_wdata,
   output logic [DW/8-1:0] s_wstrb,
   input  logic            s_ready,
   input  logic [DW-1:0]   s_rdata,
   output logic [1:0]      grant,
   output logic            err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_last;      // 1 = master 1 was served last, 0 = master 0
   logic   w_set_last;
   logic   w_err;
   logic   w_timeout;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] r_cnt;

   // Stall counter: restarts on every new grant, counts owner cycles without s_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_cnt <= '0;
      else if (r_state == ST_IDLE) r_cnt <= '0;
      else if (!s_ready)          r_cnt <= r_cnt + 1'b1;
   end

   // Fires in the cycle the count would reach the limit; a real s_ready wins
   assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !s_ready;
`else
   assign w_timeout = 1'b0;
`endif

   assign err = w_err;

   // State register; reset forces IDLE so all outputs drop asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Round-robin history: only a completed (or timed-out) transfer updates it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_last <= 1'b1;
      else if (w_set_last) r_last <= (r_state == ST_OWN1);
   end

   // Next-state decode and bus steering for the current owner
   always_comb begin
      w_next     = r_state;
      w_set_last = 1'b0;
      w_err      = 1'b0;
      grant      = 2'b00;
      s_valid    = 1'b0;
      s_addr     = '0;
      s_wdata    = '0;
      s_wstrb    = '0;
      m0_ready   = 1'b0;
      m0_rdata   = '0;
      m1_ready   = 1'b0;
      m1_rdata   = '0;
      case (r_state)
         ST_IDLE: begin
            if (m0_valid && m1_valid) w_next = r_last ? ST_OWN0 : ST_OWN1;
            else if (m0_valid)        w_next = ST_OWN0;
            else if (m1_valid)        w_next = ST_OWN1;
         end
         ST_OWN0: begin
            grant    = 2'b01;
            s_valid  = m0_valid;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_ready = m0_valid && s_ready;
            m0_rdata = s_rdata;
            if (!m0_valid) begin
               w_next = ST_IDLE;
            end else if (s_ready) begin
               w_next     = ST_IDLE;
               w_set_last = 1'b1;
            end else if (w_timeout) begin
               m0_ready   = 1'b1;
               m0_rdata   = '0;
               w_err      = 1'b1;
               w_set_last = 1'b1;
               w_next     = ST_IDLE;
            end
         end
         ST_OWN1: begin
            grant    = 2'b10;
            s_valid  = m1_valid;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_ready = m1_valid && s_ready;
            m1_rdata = s_rdata;
            if (!m1_valid) begin
               w_next = ST_IDLE;
            end else if (s_ready) begin
               w_next     = ST_IDLE;
               w_set_last = 1'b1;
            end else if (w_timeout) begin
               m1_ready   = 1'b1;
               m1_rdata   = '0;
               w_err      = 1'b1;
               w_set_last = 1'b1;
               w_next     = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule
